// File: rtl/dbg_dump_ctrl.sv
// Debug-port dump initiator: walks the CPU register file and then a RAM window
// over the read-only debug ports and streams every captured word out on valid/ready.
module dbg_dump_ctrl #(
  parameter int unsigned REG_COUNT = 32,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk_100M,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] rdbg_addr,
  input  logic [31:0] cpu_rdbg_data,
  input  logic [31:0] mem_rdbg_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_src,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int unsigned MAX_CNT = (REG_COUNT > MEM_WORDS) ? REG_COUNT : MEM_WORDS;
  localparam int unsigned IDX_W   = $clog2(MAX_CNT) + 1;
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic             PH_REG   = 1'b0;
  localparam logic             PH_MEM   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             phase_q, phase_d;
  logic [31:0]      addr_q, addr_d;
  logic             valid_q, valid_d;
  logic [31:0]      data_q, data_d;
  logic             src_q, src_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_inc_s;

  assign idx_inc_s = idx_q + IDX_ONE;

  // State register; every register advances only on enabled edges.
  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      phase_q <= PH_REG;
      addr_q  <= 32'h0000_0000;
      valid_q <= 1'b0;
      data_q  <= 32'h0000_0000;
      src_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      phase_q <= phase_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end else begin
      state_q <= state_q;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = done_q;

    // Abort takes priority over everything outside IDLE, including out_ready.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      last_d  = 1'b0;
      done_d  = 1'b0;
      busy_d  = 1'b0;
      addr_d  = 32'h0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_d = 1'b0;
          if (start && !abort) begin
            idx_d   = '0;
            addr_d  = 32'h0000_0000;
            phase_d = PH_REG;
            busy_d  = 1'b1;
            state_d = S_FETCH;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          data_d  = (phase_q == PH_MEM) ? mem_rdbg_data : cpu_rdbg_data;
          src_d   = phase_q;
          last_d  = (phase_q == PH_MEM) && (idx_q == MEM_LAST);
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
        S_PRESENT: begin
          if (out_ready) begin
            valid_d = 1'b0;
            if (last_q) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else if (phase_q == PH_MEM) begin
              idx_d   = idx_inc_s;
              addr_d  = addr_q + 32'd4;
              state_d = S_FETCH;
            end else if (idx_q == REG_LAST) begin
              phase_d = PH_MEM;
              idx_d   = '0;
              addr_d  = MEM_BASE;
              state_d = S_FETCH;
            end else begin
              idx_d   = idx_inc_s;
              addr_d  = 32'(idx_inc_s);
              state_d = S_FETCH;
            end
          end else begin
            state_d = S_PRESENT;
          end
        end
        S_DONE: begin
          done_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  assign rdbg_addr = addr_q;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_dbg_dump_ctrl.sv
// Directed bench for dbg_dump_ctrl with 32 registers and a 4-word RAM window at 0x40.
module tb_dbg_dump_ctrl;

  localparam int NREG  = 32;
  localparam int NMEM  = 4;
  localparam int TOTAL = NREG + NMEM;

  logic        clk_100M = 1'b0;
  logic        rst_n    = 1'b0;
  logic        clk_en   = 1'b1;
  logic        start    = 1'b0;
  logic        abort    = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] rdbg_addr, cpu_rdbg_data, mem_rdbg_data, out_data;
  logic        out_valid, out_src, out_last, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  dbg_dump_ctrl #(.REG_COUNT(NREG), .MEM_BASE(32'h0000_0040), .MEM_WORDS(NMEM)) dut (
    .clk_100M(clk_100M), .rst_n(rst_n), .clk_en(clk_en), .start(start), .abort(abort),
    .rdbg_addr(rdbg_addr), .cpu_rdbg_data(cpu_rdbg_data), .mem_rdbg_data(mem_rdbg_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_src(out_src),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk_100M = ~clk_100M;

  // Responder models: register i holds i*3, RAM word at 0x40+4j holds 0xA0+j.
  always_comb cpu_rdbg_data = {27'd0, rdbg_addr[4:0]} * 32'd3;
  always_comb mem_rdbg_data = 32'h0000_00A0 + ((rdbg_addr - 32'h0000_0040) >> 2);

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_100M);
    #1;
  endtask

  function automatic logic [63:0] exp_word(input int k);
    logic [31:0] d;
    logic        s;
    s = (k >= NREG);
    d = s ? (32'h0000_00A0 + 32'(k - NREG)) : (32'(k) * 32'd3);
    return {30'd0, s, (k == TOTAL - 1), d};
  endfunction

  function automatic logic [63:0] all_outs();
    return {25'd0, rdbg_addr, out_valid, out_src, out_last, busy, done, 2'b00} |
           {32'd0, out_data};
  endfunction

  // Runs one dump; stall_word/stall_len apply backpressure, half_en toggles clk_en,
  // abort_word aborts while that word is presented, hold_start keeps start high.
  task automatic run_dump(input int stall_word, input int stall_len, input bit half_en,
                          input int abort_word, input bit hold_start);
    int k = 0;
    int stall = 0;
    int cyc = 0;
    bit fin = 1'b0;
    clk_en = 1'b1; out_ready = 1'b1; abort = 1'b0;
    start = 1'b1;
    tick();
    start = hold_start;
    check_eq("busy_after_start", {63'd0, busy}, 64'd1);
    check_eq("valid_after_start", {63'd0, out_valid}, 64'd0);
    tick();
    check_eq("first_valid_latency", {63'd0, out_valid}, 64'd1);
    while (!fin && cyc < 2000) begin
      cyc++;
      clk_en    = half_en ? cyc[0] : 1'b1;
      out_ready = 1'b1;
      abort     = 1'b0;
      if (out_valid && k == stall_word && stall < stall_len) begin
        out_ready = 1'b0;
        clk_en    = 1'b1;
        stall++;
        check_eq("stall_hold", {out_valid, rdbg_addr, out_data},
                 {1'b1, 32'd2, 32'd6});
      end
      if (out_valid && k == abort_word) begin
        abort  = 1'b1;
        clk_en = 1'b1;
      end
      if (abort) begin
        tick();
        abort = 1'b0;
        check_eq("abort_outs", {61'd0, out_valid, busy, done}, 64'd0);
        check_eq("abort_addr", {32'd0, rdbg_addr}, 64'd0);
        fin = 1'b1;
      end else if (out_valid && out_ready && clk_en) begin
        check_eq($sformatf("word%0d", k), {30'd0, out_src, out_last, out_data}, exp_word(k));
        k++;
        tick();
        if (k == TOTAL) begin
          check_eq("done_pulse", {61'd0, done, busy, out_valid}, {61'd0, 3'b110});
          if (half_en) begin
            clk_en = 1'b0;
            tick();
            check_eq("done_hold_no_en", {63'd0, done}, 64'd1);
          end
          clk_en = 1'b1;
          tick();
          check_eq("done_fall", {62'd0, done, busy}, 64'd0);
          fin = 1'b1;
        end
      end else begin
        tick();
      end
    end
    if (!fin) check_eq("timeout", 64'd0, 64'd1);
    if (abort_word >= TOTAL) check_eq("word_count", 64'(k), 64'(TOTAL));
    clk_en = 1'b1;
  endtask

  initial begin
    #3;
    check_eq("reset_outs", all_outs(), 64'd0);
    #10 rst_n = 1'b1;
    tick();
    check_eq("idle_after_reset", all_outs(), 64'd0);

    run_dump(-1, 0, 1'b0, 999, 1'b0);
    run_dump(2, 5, 1'b0, 999, 1'b0);
    run_dump(-1, 0, 1'b1, 999, 1'b0);
    run_dump(-1, 0, 1'b0, 9, 1'b0);
    run_dump(-1, 0, 1'b0, 999, 1'b0);

    // Start held high: one dump, a new one starting only on the IDLE edge after DONE.
    run_dump(-1, 0, 1'b0, 999, 1'b1);
    tick();
    check_eq("restart_after_idle", {63'd0, busy}, 64'd1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("abort_restart", {63'd0, busy}, 64'd0);

    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check_eq("abort_beats_start", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of the RAM phase.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (68) tick();
    check_eq("mid_mem_phase", {63'd0, out_src}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_reset_outs", all_outs(), 64'd0);
    @(negedge clk_100M);
    rst_n = 1'b1;
    repeat (5) tick();
    check_eq("quiet_after_reset", all_outs(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dbg_dump_ctrl.md
Name: dbg_dump_ctrl

Overview:
- Debug-port initiator: on a start pulse, walks the CPU register file and then a RAM window through the read-only debug ports.
- Captures each word and presents it on a valid/ready output stream, e.g. toward a UART or host bridge.
- The CPU and rw_ram are responders on the debug interface. This block drives `rdbg_addr` and consumes their debug data.

Parameters:
REG_COUNT, 32, number of CPU registers dumped, indices 0..REG_COUNT-1 (1..32)
MEM_BASE, 32'h0000_0000, byte address of first RAM word dumped; must be 4-aligned
MEM_WORDS, 64, number of 32-bit RAM words dumped (>=1)

Ports:
clk_100M  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  clock enable; all state advances only on clk_100M rising edges with clk_en=1
start  in  1  begin dump; sampled in IDLE only
abort  in  1  cancel dump in progress
rdbg_addr  out  32  debug read address; CPU port uses [4:0]
cpu_rdbg_data  in  32  CPU register debug data, combinational from rdbg_addr
mem_rdbg_data  in  32  RAM debug data, combinational from rdbg_addr
out_valid  out  1  out_data holds a captured word
out_ready  in  1  downstream accepts word
out_data  out  32  captured word
out_src  out  1  0 = register word, 1 = memory word
out_last  out  1  current word is final word of dump
busy  out  1  high in any state except IDLE
done  out  1  one enabled-cycle pulse after final word accepted

Behaviour:
- Reset (rst_n=0, async) sets all outputs to 0: `rdbg_addr`, `out_valid`, `out_data`, `out_src`, `out_last`, `busy`, `done`. State goes to IDLE and the internal index clears to 0.
- An "edge" below means a clk_100M rising edge with clk_en=1. With clk_en=0 all state and outputs hold, including `done`.
- States: IDLE, FETCH, PRESENT, DONE.
- IDLE:
  - done=0.
  - On an edge with start=1: index<=0, rdbg_addr<=0, phase<=REG, go to FETCH.
  - start is ignored in all other states.
- FETCH (one edge):
  - out_data<=cpu_rdbg_data when phase=REG, else mem_rdbg_data.
  - out_src<=phase. out_last<=1 iff phase=MEM and index=MEM_WORDS-1. out_valid<=1.
  - Go to PRESENT.
- PRESENT:
  - Hold out_* stable while out_valid=1 and out_ready=0. No change of out_data/out_src/out_last while valid.
  - On an edge with out_ready=1: out_valid<=0.
  - If out_last: go to DONE.
  - Otherwise advance:
    - REG and index<REG_COUNT-1: index+1, rdbg_addr<=index+1.
    - REG and index=REG_COUNT-1: phase<=MEM, index<=0, rdbg_addr<=MEM_BASE.
    - MEM: index+1, rdbg_addr<=rdbg_addr+4, 32-bit wrap permitted.
    - Then go to FETCH.
- DONE: done=1 for exactly one edge, then IDLE. busy stays 1 in DONE.
- Latency and throughput:
  - First out_valid is 2 edges after the start edge.
  - Maximum throughput is 1 word per 2 edges with out_ready tied high.
  - Total words = REG_COUNT + MEM_WORDS.
- abort=1 on an edge in FETCH, PRESENT, or DONE: go to IDLE, out_valid<=0, out_last<=0, done<=0, rdbg_addr<=0.
  - abort beats out_ready on the same edge; that word counts as not transferred.
  - abort in IDLE has no effect; abort and start together in IDLE means abort wins and no dump starts.
- rdbg_addr is registered and changes only on edges. The data captured in FETCH is the value for the rdbg_addr stable since the previous edge.
- Index counter width is clog2(max(REG_COUNT, MEM_WORDS)) + 1. No overflow is possible within legal parameters.

Test Plan:
- Regs R0..R31 = i*3, MEM_WORDS=4 at MEM_BASE=0x40 holding 0xA0..0xA3, out_ready=1, start pulse -> 36 words: 32 with out_src=0 and data 0,3,...,93, then 4 with out_src=1 and data 0xA0..0xA3. out_last only on the 36th word; done pulses once, 1 edge after the last accept; busy falls with done.
- Backpressure: out_ready low for 5 edges on word 3 -> out_valid, out_data (=6), and rdbg_addr held constant throughout. No word skipped or duplicated; sequence identical to the first test.
- clk_en toggled at 50% with ready=1 -> same 36-word sequence. Each state advance occurs only on clk_en=1 edges; done stays high until the next enabled edge.
- abort asserted in PRESENT of word 10 with out_ready=1 -> word 10 not transferred, out_valid=0 next edge, no done, busy=0. A following start restarts from R0.
- start held high throughout a dump -> a single dump of 36 words. A new dump begins only on the IDLE edge after DONE.
- rst_n pulsed low mid-MEM phase (async, between edges) -> all outputs 0 immediately. After release, no activity until start.
